// File: rtl/fifo_reg_path.sv
// Registered half of an 8-deep synchronous FIFO. It holds the state register,
// the register file, the head/tail pointers, the occupancy count and the
// registered read data and status flags. The companion next-state logic
// decides which operation to attempt; this stage qualifies it and commits it.
module fifo_reg_path #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 8,
  parameter int unsigned ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic                  rd_en,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [2:0]            next_state,
  output logic [2:0]            state,
  output logic [3:0]            data_count,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty,
  output logic                  wr_ack,
  output logic                  wr_err,
  output logic                  rd_ack,
  output logic                  rd_err
);

  localparam int unsigned CNT_WIDTH = 4;

  // State encodings shared with the next-state logic
  localparam logic [2:0] ST_IDLE     = 3'b000;
  localparam logic [2:0] ST_WRITE    = 3'b001;
  localparam logic [2:0] ST_READ     = 3'b010;
  localparam logic [2:0] ST_WR_ERROR = 3'b011;
  localparam logic [2:0] ST_RD_ERROR = 3'b100;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-1:0] head;
  logic [ADDR_WIDTH-1:0] tail;

  logic wfire;
  logic rfire;
  logic werr;
  logic rerr;
  logic wr_only;
  logic rd_only;

  // Qualify the requested operation; concurrent wr_en/rd_en blocks everything
  always_comb begin
    wr_only = wr_en & ~rd_en;
    rd_only = rd_en & ~wr_en;
    wfire   = (next_state == ST_WRITE) & wr_only &
              (data_count < CNT_WIDTH'(DEPTH));
    rfire   = (next_state == ST_READ) & rd_only &
              (data_count != CNT_WIDTH'(0));
    werr    = (next_state == ST_WR_ERROR) & wr_only;
    rerr    = (next_state == ST_RD_ERROR) & rd_only;
  end

  // Status decodes from the registered count only; head==tail is ambiguous
  always_comb begin
    full  = (data_count == CNT_WIDTH'(DEPTH));
    empty = (data_count == CNT_WIDTH'(0));
  end

  // State register, pointers, occupancy, read data and event flags
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      head       <= '0;
      tail       <= '0;
      data_count <= '0;
      dout       <= '0;
      wr_ack     <= 1'b0;
      wr_err     <= 1'b0;
      rd_ack     <= 1'b0;
      rd_err     <= 1'b0;
    end else begin
      state  <= next_state;
      wr_ack <= wfire;
      wr_err <= werr;
      rd_ack <= rfire;
      rd_err <= rerr;
      if (wfire) begin
        tail       <= tail + ADDR_WIDTH'(1);
        data_count <= data_count + CNT_WIDTH'(1);
      end else if (rfire) begin
        dout       <= mem[head];
        head       <= head + ADDR_WIDTH'(1);
        data_count <= data_count - CNT_WIDTH'(1);
      end
    end
  end

  // Register file; contents are don't-care after reset so it is not cleared
  always_ff @(posedge clk) begin
    if (!reset && wfire) begin
      mem[tail] <= din;
    end
  end

endmodule

// File: doc/fifo_reg_path.md
Name: fifo_reg_path

Overview:
- Registered datapath stage directly downstream of the FIFO next-state logic.
- Registers `next_state` into `state` and feeds `state` and `data_count` back to the next-state logic.
- Holds the 8-entry register file, head/tail pointers and occupancy count, and produces registered `dout` and the ack/error/full/empty status flags.
- Together with the next-state logic it forms the complete 8-deep synchronous FIFO.

Parameters:
- DATA_WIDTH, 32, width of `din`/`dout` and of each register-file entry.
- DEPTH, 8, number of entries; fixed at 8 because `data_count` is 4 bits.
- ADDR_WIDTH, 3, pointer width; log2(DEPTH).

Ports:
- clk  input  1  rising-edge clock; the only clock.
- reset  input  1  synchronous, active-high reset.
- wr_en  input  1  write request.
- rd_en  input  1  read request.
- din  input  DATA_WIDTH  write data, sampled on the edge where a write fires.
- next_state  input  3  from the next-state logic; IDLE=000, WRITE=001, READ=010, WR_ERROR=011, RD_ERROR=100.
- state  output  3  registered current state, to the next-state logic.
- data_count  output  4  occupancy 0..8, to the next-state logic.
- dout  output  DATA_WIDTH  registered read data.
- full  output  1  data_count == 8.
- empty  output  1  data_count == 0.
- wr_ack  output  1  a write was accepted on the previous edge.
- wr_err  output  1  a write was rejected because the FIFO was full.
- rd_ack  output  1  a read was performed on the previous edge.
- rd_err  output  1  a read was rejected because the FIFO was empty.

Behaviour:
- Reset (on a clk edge with reset=1):
  - state=IDLE, head=0, tail=0, data_count=0, dout=0.
  - wr_ack=wr_err=rd_ack=rd_err=0.
  - Register-file contents are don't-care.
  - Reset mid-operation discards all stored data; full=0 and empty=1 on the first cycle after reset.
- State register: `state <= next_state` every non-reset edge. Codes 101..111 are illegal; they load as received and cause no data operation.
- Fire conditions, evaluated combinationally before the edge:
  - wfire = (next_state==WRITE) & wr_en & ~rd_en & (data_count<8).
  - rfire = (next_state==READ) & rd_en & ~wr_en & (data_count>0).
  - werr = (next_state==WR_ERROR) & wr_en & ~rd_en.
  - rerr = (next_state==RD_ERROR) & rd_en & ~wr_en.
- On wfire: mem[tail] <= din; tail <= tail+1 (wraps 7->0); data_count <= data_count+1.
- On rfire: dout <= mem[head]; head <= head+1 (wraps 7->0); data_count <= data_count-1.
- dout holds its last value whenever rfire=0.
- Flags: wr_ack, rd_ack, wr_err and rd_err are registered copies of wfire, rfire, werr and rerr. They are high for exactly one cycle per event and go high in the same cycle that `state` shows the corresponding state.
- full and empty are combinational decodes of the registered data_count.
- Latency:
  - Write: visible in data_count and wr_ack 1 cycle after the edge it fires on.
  - Read: dout valid and rd_ack high 1 cycle after the request edge.
  - First-word fall-through is not supported.
- Boundary rules:
  - wr_en=rd_en=1: no data operation and no flags, regardless of next_state. Pointers and count are held; state still loads next_state.
  - Write at count 8: no register-file change, count stays 8, tail unchanged. wr_err fires only if next_state==WR_ERROR.
  - Read at count 0: dout unchanged, head unchanged. rd_err fires only if next_state==RD_ERROR.
  - Pointer wrap: head==tail occurs both at count 0 and count 8; full and empty are derived only from data_count, never from pointer comparison.
  - data_count never leaves 0..8. wfire and rfire are mutually exclusive by construction.
- Ordering: strict FIFO; data is read in the same order it was written, across wrap.

Test Plan:
- Reset: hold reset 2 cycles during traffic -> state=000, data_count=0, empty=1, full=0, dout=0, all ack/err flags 0.
- Fill and overflow: 8 writes of 0x11..0x88 with next_state=WRITE -> wr_ack high each cycle, data_count reaches 8, full=1. A 9th write with next_state=WR_ERROR -> wr_err=1 for one cycle, data_count stays 8, mem unchanged.
- Drain and underflow: 8 reads with next_state=READ -> dout sequence 0x11..0x88, rd_ack each cycle, empty=1 at the end. A 9th read with next_state=RD_ERROR -> rd_err=1, dout stays 0x88.
- Wrap-around: write 6, read 6, write 5 of 0xA0..0xA4, read 5 -> dout 0xA0..0xA4 in order, head and tail both wrap past 7, data_count returns to 0.
- Simultaneous wr_en=rd_en=1 at data_count=3 for 3 cycles -> data_count stays 3, dout unchanged, no ack or err flags.
- Reset mid-operation: after 5 writes, assert reset for 1 cycle, then read with next_state=RD_ERROR -> data_count=0, rd_err=1, dout=0.
